// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | mem_port_arbiter_if: fetch, data and memory-side signals of the arbiter |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic              if_req;
  logic [AW-1:0]     if_addr;
  logic [DW-1:0]     if_rdata;
  logic              if_ack;
  logic              dm_read;
  logic              dm_write;
  logic [AW-1:0]     dm_addr;
  logic [DW-1:0]     dm_wdata;
  logic [DW/8-1:0]   dm_be;
  logic [DW-1:0]     dm_rdata;
  logic              dm_ack;
  logic              mem_req;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW/8-1:0]   mem_be;
  logic              mem_ready;
  logic [DW-1:0]     mem_rdata;
  logic              stall_if;
  logic              stall_mem;
  logic              bus_err;

  modport slave (
    input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, dm_be,
           mem_ready, mem_rdata,
    output if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr,
           mem_wdata, mem_be, stall_if, stall_mem, bus_err
  );

  modport master (
    output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, dm_be,
           mem_ready, mem_rdata,
    input  if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr,
           mem_wdata, mem_be, stall_if, stall_mem, bus_err
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | mem_port_arbiter: shares one memory port between IF and MEM stages,     |
// | with stall generation and a hung-transaction watchdog.                  |
// | MEM_ARB_RR_EN: round-robin between ports instead of data-first priority.|
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  localparam int           CW        = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] C_TO_LAST = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam bit           C_WDOG_EN = (TIMEOUT_CYC != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GNT_IF = 2'd1,
    S_GNT_DM = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_wdog;

  logic w_dm_req;
  logic w_dm_pend;
  logic w_if_pend;
  logic w_grant_dm;
  logic w_timeout;

  // A request whose ack is high this cycle has already been served.
  assign w_dm_req  = bus.dm_read | bus.dm_write;
  assign w_dm_pend = w_dm_req & ~bus.dm_ack;
  assign w_if_pend = bus.if_req & ~bus.if_ack;
  assign w_timeout = C_WDOG_EN && (r_wdog == C_TO_LAST) && !bus.mem_ready;

`ifdef MEM_ARB_RR_EN
  logic r_last_dm;
  assign w_grant_dm = w_dm_pend & (~w_if_pend | ~r_last_dm);
`else
  assign w_grant_dm = w_dm_pend;
`endif

  assign bus.stall_mem = w_dm_req & ~bus.dm_ack;
  assign bus.stall_if  = bus.stall_mem | (bus.if_req & ~bus.if_ack);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_wdog        <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
      bus.if_ack    <= 1'b0;
      bus.dm_ack    <= 1'b0;
      bus.bus_err   <= 1'b0;
      bus.if_rdata  <= '0;
      bus.dm_rdata  <= '0;
`ifdef MEM_ARB_RR_EN
      r_last_dm     <= 1'b0;
`endif
    end else begin
      bus.if_ack  <= 1'b0;
      bus.dm_ack  <= 1'b0;
      bus.bus_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_dm) begin
            r_state       <= S_GNT_DM;
            r_wdog        <= '0;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.dm_write;
            bus.mem_addr  <= bus.dm_addr;
            bus.mem_wdata <= bus.dm_wdata;
            bus.mem_be    <= bus.dm_be;
`ifdef MEM_ARB_RR_EN
            r_last_dm     <= 1'b1;
`endif
          end else if (w_if_pend) begin
            r_state      <= S_GNT_IF;
            r_wdog       <= '0;
            bus.mem_req  <= 1'b1;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= bus.if_addr;
            bus.mem_be   <= '1;
`ifdef MEM_ARB_RR_EN
            r_last_dm    <= 1'b0;
`endif
          end
        end
        S_GNT_IF: begin
          if (bus.mem_ready) begin
            r_state      <= S_IDLE;
            bus.mem_req  <= 1'b0;
            bus.if_rdata <= bus.mem_rdata;
            bus.if_ack   <= 1'b1;
          end else if (w_timeout) begin
            r_state      <= S_IDLE;
            bus.mem_req  <= 1'b0;
            bus.if_rdata <= '0;
            bus.if_ack   <= 1'b1;
            bus.bus_err  <= 1'b1;
          end else begin
            r_wdog <= r_wdog + CW'(1);
          end
        end
        S_GNT_DM: begin
          if (bus.mem_ready) begin
            r_state      <= S_IDLE;
            bus.mem_req  <= 1'b0;
            bus.dm_rdata <= bus.mem_we ? '0 : bus.mem_rdata;
            bus.dm_ack   <= 1'b1;
          end else if (w_timeout) begin
            r_state      <= S_IDLE;
            bus.mem_req  <= 1'b0;
            bus.dm_rdata <= '0;
            bus.dm_ack   <= 1'b1;
            bus.bus_err  <= 1'b1;
          end else begin
            r_wdog <= r_wdog + CW'(1);
          end
        end
        default: begin
          r_state     <= S_IDLE;
          bus.mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter              |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  exp_t q_if[$];
  exp_t q_dm[$];
  exp_t e_if;
  exp_t e_dm;

  int wait_cyc = 0;
  bit mem_hang = 1'b0;
  int wcnt = 0;
  int txn_cnt = 0;
  int req_cycles = 0;
  int if_acks = 0;
  int dm_acks = 0;
  bit prev_if_ack = 1'b0;
  bit prev_dm_ack = 1'b0;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h40) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory responder: answers after wait_cyc wait cycles unless hung.
  always @(negedge clk) begin
    if (bus.mem_req) req_cycles++;
    if (bus.mem_req && !mem_hang && !reset) begin
      if (wcnt >= wait_cyc) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = mem_model(bus.mem_addr);
        wcnt = 0;
      end else begin
        bus.mem_ready = 1'b0;
        wcnt++;
      end
    end else begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      wcnt = 0;
    end
  end

  always @(posedge clk) if (bus.mem_req && bus.mem_ready) txn_cnt++;

  // Scoreboard: pop expected result on every ack pulse.
  always @(negedge clk) begin
    if (bus.if_ack) begin
      if_acks++;
      checks++;
      if (prev_if_ack) begin
        errors++;
        $display("FAIL if_ack_pulse got two-cycle if_ack want single cycle");
      end
      checks++;
      if (q_if.size() == 0) begin
        errors++;
        $display("FAIL if_ack_unexpected got if_ack=1 want 0");
      end else begin
        e_if = q_if.pop_front();
        if ({bus.if_rdata, bus.bus_err} !== {e_if.data, e_if.err}) begin
          errors++;
          $display("FAIL if_result got rdata=%h err=%b want rdata=%h err=%b",
                   bus.if_rdata, bus.bus_err, e_if.data, e_if.err);
        end
      end
    end
    if (bus.dm_ack) begin
      dm_acks++;
      checks++;
      if (prev_dm_ack) begin
        errors++;
        $display("FAIL dm_ack_pulse got two-cycle dm_ack want single cycle");
      end
      checks++;
      if (q_dm.size() == 0) begin
        errors++;
        $display("FAIL dm_ack_unexpected got dm_ack=1 want 0");
      end else begin
        e_dm = q_dm.pop_front();
        if ({bus.dm_rdata, bus.bus_err} !== {e_dm.data, e_dm.err}) begin
          errors++;
          $display("FAIL dm_result got rdata=%h err=%b want rdata=%h err=%b",
                   bus.dm_rdata, bus.bus_err, e_dm.data, e_dm.err);
        end
      end
    end
    if (bus.bus_err && !bus.if_ack && !bus.dm_ack) begin
      checks++;
      errors++;
      $display("FAIL bus_err_alone got bus_err=1 want 0 without ack");
    end
    prev_if_ack = bus.if_ack;
    prev_dm_ack = bus.dm_ack;
  end

  task automatic test_reset();
    reset        = 1'b1;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.dm_read  = 1'b0;
    bus.dm_write = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
    bus.dm_be    = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be} !== '0) begin
      errors++;
      $display("FAIL reset_mem got req=%b we=%b addr=%h wdata=%h be=%b want all 0",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be);
    end
    checks++;
    if ({bus.if_ack, bus.dm_ack, bus.bus_err, bus.if_rdata, bus.dm_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_resp got if_ack=%b dm_ack=%b err=%b if_rdata=%h dm_rdata=%h want all 0",
               bus.if_ack, bus.dm_ack, bus.bus_err, bus.if_rdata, bus.dm_rdata);
    end
    checks++;
    if ({bus.stall_if, bus.stall_mem} !== 2'b00) begin
      errors++;
      $display("FAIL reset_stall got stall_if=%b stall_mem=%b want 0 0", bus.stall_if, bus.stall_mem);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    bit done = 1'b0;
    wait_cyc   = 2;
    req_cycles = 0;
    q_if.push_back('{32'h0050_0093, 1'b0});
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h40;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      checks++;
      if (bus.if_ack) begin
        if (bus.stall_if !== 1'b0) begin
          errors++;
          $display("FAIL fetch_stall_ack got stall_if=%b want 0", bus.stall_if);
        end
        bus.if_req = 1'b0;
        done = 1'b1;
      end else if (bus.stall_if !== 1'b1) begin
        errors++;
        $display("FAIL fetch_stall_wait got stall_if=%b want 1", bus.stall_if);
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL fetch_timeout got no if_ack want if_ack within 20 cycles");
    end
    @(negedge clk);
    checks++;
    if (req_cycles != 3) begin
      errors++;
      $display("FAIL fetch_req_len got %0d cycles want 3", req_cycles);
    end
  endtask

  task automatic test_store();
    bit done = 1'b0;
    bit seen = 1'b0;
    wait_cyc = 1;
    q_dm.push_back('{32'h0, 1'b0});
    bus.dm_write = 1'b1;
    bus.dm_addr  = 32'h200;
    bus.dm_wdata = 32'hDEAD_BEEF;
    bus.dm_be    = 4'b0011;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.mem_req && !seen) begin
        seen = 1'b1;
        checks++;
        if ({bus.mem_we, bus.mem_be, bus.mem_wdata, bus.mem_addr} !== {1'b1, 4'b0011, 32'hDEAD_BEEF, 32'h200}) begin
          errors++;
          $display("FAIL store_bus got we=%b be=%b wdata=%h addr=%h want 1 0011 deadbeef 00000200",
                   bus.mem_we, bus.mem_be, bus.mem_wdata, bus.mem_addr);
        end
        checks++;
        if (bus.stall_mem !== 1'b1) begin
          errors++;
          $display("FAIL store_stall got stall_mem=%b want 1", bus.stall_mem);
        end
      end
      if (bus.dm_ack) begin
        bus.dm_write = 1'b0;
        done = 1'b1;
      end
    end
    checks++;
    if (!done || !seen) begin
      errors++;
      $display("FAIL store_timeout got done=%b req_seen=%b want 1 1", done, seen);
    end
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    bit if_done = 1'b0;
    bit dm_done = 1'b0;
    int if_c = 0;
    int dm_c = 0;
    wait_cyc = 0;
    q_if.push_back('{mem_model(32'h300), 1'b0});
    q_dm.push_back('{mem_model(32'h100), 1'b0});
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h300;
    bus.dm_read = 1'b1;
    bus.dm_addr = 32'h100;
    for (int i = 0; i < 30 && !(if_done && dm_done); i++) begin
      @(negedge clk);
      if (!if_done && !bus.if_ack) begin
        checks++;
        if (bus.stall_if !== 1'b1) begin
          errors++;
          $display("FAIL sim_stall got stall_if=%b want 1", bus.stall_if);
        end
      end
      if (bus.dm_ack) begin
        dm_c = cyc;
        dm_done = 1'b1;
        bus.dm_read = 1'b0;
      end
      if (bus.if_ack) begin
        if_c = cyc;
        if_done = 1'b1;
        bus.if_req = 1'b0;
      end
    end
    checks++;
`ifdef MEM_ARB_RR_EN
    if (!(if_done && dm_done) || (dm_c - if_c) != 2) begin
      errors++;
      $display("FAIL sim_order got dm_ack-if_ack=%0d want 2", dm_c - if_c);
    end
`else
    if (!(if_done && dm_done) || (if_c - dm_c) != 2) begin
      errors++;
      $display("FAIL sim_order got if_ack-dm_ack=%0d want 2", if_c - dm_c);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit done = 1'b0;
    int t0 = txn_cnt;
    int a0 = dm_acks;
    wait_cyc = 0;
    q_dm.push_back('{mem_model(32'h180), 1'b0});
    bus.dm_read = 1'b1;
    bus.dm_addr = 32'h180;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.dm_ack) done = 1'b1;
    end
    @(negedge clk);
    bus.dm_read = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (!done || (txn_cnt - t0) != 1 || (dm_acks - a0) != 1) begin
      errors++;
      $display("FAIL held_req got txns=%0d acks=%0d want 1 1", txn_cnt - t0, dm_acks - a0);
    end
  endtask

  task automatic test_watchdog();
    bit done = 1'b0;
    mem_hang   = 1'b1;
    req_cycles = 0;
    q_if.push_back('{32'h0, 1'b1});
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h80;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.if_ack) begin
        bus.if_req = 1'b0;
        done = 1'b1;
      end
    end
    @(negedge clk);
    checks++;
    if (!done || req_cycles != TO) begin
      errors++;
      $display("FAIL wdog_len got done=%b req_cycles=%0d want 1 %0d", done, req_cycles, TO);
    end
    mem_hang = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    int n = 0;
    int a_if = if_acks;
    int a_dm = dm_acks;
    mem_hang    = 1'b1;
    bus.dm_read = 1'b1;
    bus.dm_addr = 32'h240;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_req) seen = 1'b1;
    end
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (!seen || {bus.mem_req, bus.dm_ack, bus.bus_err} !== 3'b000) begin
      errors++;
      $display("FAIL rst_async got seen=%b req=%b dm_ack=%b err=%b want 1 0 0 0",
               seen, bus.mem_req, bus.dm_ack, bus.bus_err);
    end
    bus.dm_read = 1'b0;
    @(negedge clk);
    reset    = 1'b0;
    mem_hang = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b0 || if_acks != a_if || dm_acks != a_dm) begin
      errors++;
      $display("FAIL rst_idle got req=%b new_acks=%0d want 0 0",
               bus.mem_req, (if_acks - a_if) + (dm_acks - a_dm));
    end
    wait_cyc = 0;
    q_if.push_back('{32'h0050_0093, 1'b0});
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h40;
    for (int i = 0; i < 10 && n == 0; i++) begin
      @(negedge clk);
      if (bus.if_ack) n = i + 1;
    end
    bus.if_req = 1'b0;
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL rst_latency got ack after %0d cycles want 2", n);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_simultaneous();
    test_back_to_back();
    test_watchdog();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (q_if.size() != 0 || q_dm.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got if=%0d dm=%0d pending want 0 0", q_if.size(), q_dm.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (loads/stores qualified by MemRead/MemWrite).
- Serialises requests through a grant FSM and drives the memory req/ready handshake.
- Returns per-requester data and ack pulses, and drives pipeline stall lines so the 5-stage pipeline freezes while either port waits.
- Includes a watchdog that aborts hung memory transactions.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT_CYC, 16, cycles a granted transaction may wait for mem_ready before abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request, held until if_ack.
- if_addr  in  AW  fetch address.
- if_rdata  out  DW  fetched instruction, valid while if_ack=1.
- if_ack  out  1  one-cycle completion pulse for the fetch.
- dm_read  in  1  load request (MemRead), held until dm_ack.
- dm_write  in  1  store request (MemWrite), held until dm_ack.
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  store data.
- dm_be  in  DW/8  byte enables for sb/sh/sw.
- dm_rdata  out  DW  load data, valid while dm_ack=1.
- dm_ack  out  1  one-cycle completion pulse for the data access.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_be  out  DW/8  memory byte enables.
- mem_ready  in  1  memory completion; read data valid in the same cycle.
- mem_rdata  in  DW  memory read data.
- stall_if  out  1  freeze PC and IF/ID registers.
- stall_mem  out  1  freeze EX/MEM and all upstream registers.
- bus_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- States: IDLE, GNT_IF, GNT_DM.
- Reset values (async): state=IDLE; mem_req, mem_we, if_ack, dm_ack and bus_err = 0; mem_addr, mem_wdata, mem_be, if_rdata, dm_rdata and watchdog counter = 0.
- The memory-side outputs are registered.

IDLE:
- A port is "pending" if it is requesting and its ack is not high in the current cycle. This prevents re-granting a request the pipeline has not yet retired.
- dm pending: enter GNT_DM. Load mem_addr/mem_wdata/mem_be from the dm inputs; mem_we=dm_write; mem_req=1.
- Otherwise, if_req pending: enter GNT_IF. mem_we=0, mem_be=all ones, mem_req=1.
- dm_read and dm_write both high: treated as a write.

GNT_x:
- mem_* outputs are held stable while mem_req=1 and mem_ready=0.
- On an edge with mem_ready=1:
  - mem_req goes to 0 and state returns to IDLE.
  - x_rdata <= mem_rdata; for stores, dm_rdata <= 0.
  - x_ack=1 for exactly the next cycle.
- Minimum latency: request sampled at edge k gives mem_req=1 after k; with mem_ready=1 in that cycle, ack=1 after edge k+1.
- Back-to-back: IDLE may grant the other port in the same cycle an ack is high.

Stalls (combinational):
- stall_mem = (dm_read|dm_write) & ~dm_ack.
- stall_if = stall_mem | (if_req & ~if_ack).

Watchdog:
- The counter clears on each grant and increments each cycle in GNT_x with mem_ready=0.
- When the counter reaches TIMEOUT_CYC-1 with mem_ready still 0:
  - mem_req goes to 0 and state returns to IDLE.
  - x_ack=1, x_rdata=0, bus_err=1, each for one cycle.

Reset:
- Reset mid-transaction drops mem_req immediately; no ack is issued.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: a 1-bit last-grant register (reset 0 = IF) is updated on each grant. When both ports are pending in IDLE, the port not granted last wins.
- Undefined: fixed priority, data port always wins (oldest instruction first). The register is not built.

Test Plan:
- Fetch only: if_req=1, addr 0x40, mem_ready after 2 wait cycles, mem_rdata=0x00500093 -> mem_req high 3 cycles; if_ack single pulse with if_rdata=0x00500093; stall_if deasserts in the ack cycle.
- Simultaneous requests: if_req=1, dm_read=1 at 0x100, zero-wait memory.
  - Fixed priority: DM granted first; dm_ack precedes if_ack by 2 cycles; stall_if stays high throughout.
  - MEM_ARB_RR_EN after a prior DM grant: IF is granted first.
- Store: dm_write=1, addr 0x200, wdata 0xDEADBEEF, be 0011 -> mem_we=1, mem_be=0011, mem_wdata=0xDEADBEEF; dm_ack pulse; dm_rdata=0.
- Held request in ack cycle: dm_read kept high during the dm_ack cycle, then dropped -> exactly one memory transaction, no duplicate grant.
- Watchdog: TIMEOUT_CYC=16, mem_ready never asserted -> mem_req drops after 16 cycles; if_ack=1, bus_err=1, if_rdata=0, each for one cycle.
- Reset mid-GNT_DM: reset pulse while mem_req=1 -> mem_req, dm_ack and bus_err go to 0 asynchronously; state is IDLE after reset release.
